// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Sequencing controller for a multi-cycle RV32I datapath with handshaked
// instruction and data memories. It steps each instruction through fetch,
// decode, execute, memory and writeback, and drives every state-update
// enable and the PC and register-write mux selects. It also flags illegal
// encodings and memory timeouts, and counts retired instructions.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | imem request held until imem_ready; IR loads on ready
// DECODE    | classify the IR contents: legal, system (halt) or illegal
// EXECUTE   | ALU/jump/branch retire here; loads/stores move on to MEM
// MEM       | dmem read/write held until dmem_ready; stores retire here
// WRITEBACK | load data (MDR) goes into the register file; retire
// HALT      | absorbing; only reset_n leaves it

module multicycle_control_fsm #(
  parameter int MAX_WAIT  = 15,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 alu_eq,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 mdr_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 pc_write,
  output logic [1:0]           rd_sel,
  output logic [2:0]           pc_sel,
  output logic [2:0]           state_out,
  output logic                 halted,
  output logic                 illegal,
  output logic                 timeout,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  // Instruction class captured in DECODE so later states do not depend on
  // the IR staying untouched.
  typedef enum logic [2:0] {
    C_ALU    = 3'd0,
    C_JAL    = 3'd1,
    C_JALR   = 3'd2,
    C_BRANCH = 3'd3,
    C_LOAD   = 3'd4,
    C_STORE  = 3'd5
  } iclass_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] RD_ALU = 2'd0;
  localparam logic [1:0] RD_MDR = 2'd1;
  localparam logic [1:0] RD_PC4 = 2'd2;

  localparam logic [2:0] PC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_JAL    = 3'd1;
  localparam logic [2:0] PC_ALU    = 3'd2;
  localparam logic [2:0] PC_BRANCH = 3'd3;

  // A request unanswered while the counter sits at MAX_WAIT-1 would make
  // the count reach MAX_WAIT, so that is the cycle the timeout fires in.
  localparam logic [7:0]           WAIT_LAST   = 8'(MAX_WAIT - 1);
  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  state_t        state;
  iclass_t       iclass;
  logic          br_ne;
  logic [7:0]    wait_cnt;

  logic          dec_legal;
  logic          dec_system;
  iclass_t       dec_class;

  assign state_out = state;

  // Classify the instruction register contents for DECODE.
  always_comb begin
    dec_legal  = 1'b0;
    dec_system = 1'b0;
    dec_class  = C_ALU;
    case (opcode)
      OP_R, OP_I, OP_LUI: begin
        dec_legal = 1'b1;
        dec_class = C_ALU;
      end
      OP_LOAD: begin
        dec_legal = (funct3 == 3'b010);
        dec_class = C_LOAD;
      end
      OP_STORE: begin
        dec_legal = (funct3 == 3'b010);
        dec_class = C_STORE;
      end
      OP_JAL: begin
        dec_legal = 1'b1;
        dec_class = C_JAL;
      end
      OP_JALR: begin
        dec_legal = (funct3 == 3'b000);
        dec_class = C_JALR;
      end
      OP_BRANCH: begin
        dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
        dec_class = C_BRANCH;
      end
      OP_SYSTEM: begin
        dec_system = 1'b1;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // State sequencing, wait counter, sticky flags and retired-instruction count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      iclass   <= C_ALU;
      br_ne    <= 1'b0;
      wait_cnt <= 8'd0;
      instret  <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
          end
        end

        S_FETCH: begin
          // Ready wins over a simultaneous timeout.
          if (imem_ready) begin
            state    <= S_DECODE;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= S_HALT;
            wait_cnt <= 8'd0;
            timeout  <= 1'b1;
            halted   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_DECODE: begin
          wait_cnt <= 8'd0;
          if (dec_system) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!dec_legal) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else begin
            state  <= S_EXECUTE;
            iclass <= dec_class;
            // Legal branches are BEQ (000) or BNE (001); bit 0 picks the sense.
            br_ne  <= funct3[0];
          end
        end

        S_EXECUTE: begin
          wait_cnt <= 8'd0;
          if (iclass == C_LOAD || iclass == C_STORE) begin
            state <= S_MEM;
          end else begin
            state   <= S_FETCH;
            instret <= instret + INSTRET_ONE;
          end
        end

        S_MEM: begin
          if (dmem_ready) begin
            wait_cnt <= 8'd0;
            if (iclass == C_LOAD) begin
              state <= S_WRITEBACK;
            end else begin
              state   <= S_FETCH;
              instret <= instret + INSTRET_ONE;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= S_HALT;
            wait_cnt <= 8'd0;
            timeout  <= 1'b1;
            halted   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_WRITEBACK: begin
          wait_cnt <= 8'd0;
          state    <= S_FETCH;
          instret  <= instret + INSTRET_ONE;
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state    <= S_IDLE;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Enables and mux selects: decoded from state, with ready-gated pulses and
  // the branch decision passing straight through in the same cycle.
  always_comb begin
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    rd_sel    = RD_ALU;
    pc_sel    = PC_PLUS4;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end

      S_EXECUTE: begin
        case (iclass)
          C_ALU: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
          end
          C_JAL: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            rd_sel    = RD_PC4;
            pc_sel    = PC_JAL;
          end
          C_JALR: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            rd_sel    = RD_PC4;
            pc_sel    = PC_ALU;
          end
          C_BRANCH: begin
            pc_write = 1'b1;
            // BEQ taken on alu_eq, BNE taken on !alu_eq.
            if (alu_eq ^ br_ne) begin
              pc_sel = PC_BRANCH;
            end
          end
          default: begin
            pc_write = 1'b0;
          end
        endcase
      end

      S_MEM: begin
        if (iclass == C_LOAD) begin
          mem_read  = 1'b1;
          mdr_write = dmem_ready;
        end else begin
          mem_write = 1'b1;
          pc_write  = dmem_ready;
        end
      end

      S_WRITEBACK: begin
        reg_write = 1'b1;
        rd_sel    = RD_MDR;
        pc_write  = 1'b1;
      end

      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the RV32I datapath when it moves from single-cycle to multi-cycle operation with handshaked instruction and data memories.
- Sits beside the existing combinational decoder, which still supplies alu_op and the sign-extend type.
- Owns the instruction sequence: fetch, decode, execute, memory, writeback. Generates every state-update enable and the PC and register-write mux selects.
- Detects illegal encodings and memory timeouts, and counts retired instructions.

Parameters:
- MAX_WAIT, 15: cycles a memory request may stay unanswered before a timeout fault; range 1..255.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset_n, input, 1: reset, asynchronous active-low.
- start, input, 1: leave IDLE and begin fetching.
- opcode, input, 7: instruction register bits [6:0].
- funct3, input, 3: instruction register bits [14:12].
- alu_eq, input, 1: ALU equality flag for branches.
- imem_ready, input, 1: instruction memory data valid this cycle.
- dmem_ready, input, 1: data memory read data valid or write accepted this cycle.
- imem_req, output, 1: instruction fetch request.
- ir_write, output, 1: load the instruction register.
- mdr_write, output, 1: load the memory data register.
- mem_read, output, 1: data memory read request.
- mem_write, output, 1: data memory write request.
- reg_write, output, 1: register file write enable.
- pc_write, output, 1: PC register load.
- rd_sel, output, 2: register data select; 0 ALU, 1 MDR, 2 pc+4.
- pc_sel, output, 3: PC source; 0 pc+4, 1 jal, 2 ALU, 3 branch.
- state_out, output, 3: current state encoding.
- halted, output, 1: sticky halt flag.
- illegal, output, 1: sticky illegal-instruction flag.
- timeout, output, 1: sticky memory-timeout flag.
- instret, output, INSTRET_W: retired instruction count.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6.
- Reset: the async assert of reset_n forces IDLE immediately, even mid-handshake.
  - instret, the wait counter, halted, illegal and timeout clear to 0.
  - Every enable/request output is 0; rd_sel=0, pc_sel=0.
- Output style: outputs are combinational from state. Pulses gated by ready and pc_sel for branches are Mealy. All unlisted outputs are 0 in each state.
- IDLE: start=1 -> FETCH.
- FETCH: imem_req=1 held until imem_ready.
  - On imem_ready: ir_write=1 that cycle; clear the wait counter; -> DECODE.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT without ready: timeout=1, halted=1, -> HALT.
- DECODE: one cycle; checks the registered opcode/funct3.
  - Legal: 0110011 (any funct3); 0010011 (any); 0110111; 0000011 and 0100011 with funct3=010 only; 1101111; 1100111 with funct3=000; 1100011 with funct3 000/001.
  - 1110011 -> HALT with halted=1 and no fault.
  - Any other encoding -> HALT with illegal=1 and halted=1.
  - Legal instruction -> EXECUTE.
- EXECUTE, for loads/stores (0000011/0100011): -> MEM; no enables asserted.
- EXECUTE, all other legal instructions: pc_write=1, instret+=1, -> FETCH.
  - ALU-R/ALU-I/LUI: reg_write=1, rd_sel=0, pc_sel=0.
  - JAL: reg_write=1, rd_sel=2, pc_sel=1.
  - JALR: reg_write=1, rd_sel=2, pc_sel=2.
  - Branch: reg_write=0. pc_sel=3 if (funct3=000 & alu_eq) or (funct3=001 & !alu_eq), else pc_sel=0.
- MEM: mem_read=1 (load) or mem_write=1 (store) held until dmem_ready; same MAX_WAIT timeout rule as FETCH.
  - Load, on ready: mdr_write=1; -> WRITEBACK.
  - Store, on ready: pc_write=1, pc_sel=0, instret+=1; -> FETCH.
- WRITEBACK: reg_write=1, rd_sel=1, pc_write=1, pc_sel=0, instret+=1; -> FETCH.
- HALT: absorbing state; only reset_n exits.
  - Ready inputs are ignored; start is ignored in HALT and outside IDLE.
- Wait counter: 8 bits; cleared on every state change.
  - Ready in the same cycle the count hits MAX_WAIT counts as success; ready wins.
- instret wraps modulo 2^INSTRET_W with no flag.
- Latency with zero-wait memories:
  - ALU, jump and branch instructions: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Test Plan:
- ADDI: reset, start, imem_ready always 1, opcode=0010011 -> states 1,2,3; EXECUTE shows reg_write=1, pc_write=1, rd_sel=0; instret=1 after 3 cycles.
- LW with dmem_ready low 2 cycles: MEM holds mem_read=1 for 3 cycles; mdr_write=1 only in the ready cycle; WRITEBACK has reg_write=1, rd_sel=1; instret=1 after 7 cycles.
- Branches: BNE with alu_eq=0 -> pc_sel=3 in EXECUTE. BNE with alu_eq=1 -> pc_sel=0. BEQ with alu_eq=1 -> pc_sel=3. reg_write=0 in all three cases.
- Illegal and system encodings: opcode=0000011 with funct3=000 -> HALT with illegal=1, halted=1, instret unchanged; start pulses afterward have no effect. opcode=1110011 -> halted=1, illegal=0.
- Timeout: MAX_WAIT=4, imem_ready never asserted -> after 4 FETCH cycles timeout=1, state_out=6.
- Reset mid-operation: reset_n low during MEM with mem_write=1 -> mem_write, state_out and instret go to 0 immediately, without waiting for a clock edge.
